// File: rtl/lfsr_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_run_controller
// Description : Command sequencer for an 8-bit LFSR. It handles seed load,
//               run-N and step commands, zero-lockup recovery, and round-robin
//               synapse feedback arbitration.
// Revision    : 1.0
// ============================================================================
module lfsr_run_controller #(
    parameter logic [7:0] SEED_DEFAULT = 8'hA5,
    parameter int         HOLD_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [7:0] cmd_arg_i,
    input  logic [7:0] lfsr_q_i,
    input  logic       excite_req_i,
    input  logic       inhibit_req_i,
    output logic       lfsr_en_o,
    output logic       lfsr_load_o,
    output logic [7:0] lfsr_seed_o,
    output logic [1:0] fb_sel_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       lockup_o
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_LOAD    = 3'd1;
    localparam logic [2:0] c_RUN     = 3'd2;
    localparam logic [2:0] c_RECOVER = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    localparam logic [1:0] c_OP_NOP  = 2'd0;
    localparam logic [1:0] c_OP_LOAD = 2'd1;
    localparam logic [1:0] c_OP_RUN  = 2'd2;
    localparam logic [1:0] c_OP_STEP = 2'd3;

    localparam logic [1:0] c_FB_NATIVE  = 2'd0;
    localparam logic [1:0] c_FB_EXCITE  = 2'd1;
    localparam logic [1:0] c_FB_INHIBIT = 2'd2;

    logic [2:0]    r_state;
    logic [8:0]    r_steps;
    logic [HW-1:0] r_hold;
    logic          r_pend_e;
    logic          r_pend_i;
    logic          r_rr_inhibit;

    logic          w_accept;
    logic          w_arb;
    logic          w_grant_e;
    logic          w_grant_i;

    assign cmd_ready_o = (r_state == c_IDLE);
    assign busy_o      = (r_state != c_IDLE);
    assign w_accept    = cmd_valid_i && cmd_ready_o;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= c_IDLE;
            r_steps     <= 9'd0;
            lfsr_en_o   <= 1'b0;
            lfsr_load_o <= 1'b0;
            lfsr_seed_o <= SEED_DEFAULT;
            done_o      <= 1'b0;
            lockup_o    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        lockup_o <= 1'b0;
                        case (cmd_op_i)
                            c_OP_LOAD: begin
                                r_state     <= c_LOAD;
                                lfsr_load_o <= 1'b1;
                                lfsr_seed_o <= (cmd_arg_i == 8'd0) ? SEED_DEFAULT : cmd_arg_i;
                            end
                            c_OP_RUN, c_OP_STEP: begin
                                r_state   <= c_RUN;
                                lfsr_en_o <= 1'b1;
                                if (cmd_op_i == c_OP_STEP)
                                    r_steps <= 9'd1;
                                else
                                    r_steps <= (cmd_arg_i == 8'd0) ? 9'd256 : {1'b0, cmd_arg_i};
                            end
                            default: ;
                        endcase
                    end
                end
                c_LOAD: begin
                    lfsr_load_o <= 1'b0;
                    done_o      <= 1'b1;
                    r_state     <= c_DONE;
                end
                c_RUN: begin
                    // The enabled cycle that exposes the zero state still counts as a step.
                    r_steps <= r_steps - 9'd1;
                    if (lfsr_q_i == 8'd0) begin
                        r_state     <= c_RECOVER;
                        lfsr_en_o   <= 1'b0;
                        lfsr_load_o <= 1'b1;
                        lfsr_seed_o <= SEED_DEFAULT;
                        lockup_o    <= 1'b1;
                    end else if (r_steps == 9'd1) begin
                        r_state   <= c_DONE;
                        lfsr_en_o <= 1'b0;
                        done_o    <= 1'b1;
                    end
                end
                c_RECOVER: begin
                    lfsr_load_o <= 1'b0;
                    if (r_steps == 9'd0) begin
                        r_state <= c_DONE;
                        done_o  <= 1'b1;
                    end else begin
                        r_state   <= c_RUN;
                        lfsr_en_o <= 1'b1;
                    end
                end
                c_DONE: begin
                    done_o  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state     <= c_IDLE;
                    lfsr_en_o   <= 1'b0;
                    lfsr_load_o <= 1'b0;
                    done_o      <= 1'b0;
                end
            endcase
        end
    end

    // Re-arbitrate in the last held cycle so a source keeps feedback for exactly HOLD_CYCLES enables.
    assign w_arb     = lfsr_en_o && ((r_hold == '0) || (r_hold == HW'(1)));
    assign w_grant_e = w_arb && r_pend_e && (!r_pend_i || !r_rr_inhibit);
    assign w_grant_i = w_arb && r_pend_i && !w_grant_e;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_pend_e     <= 1'b0;
            r_pend_i     <= 1'b0;
            r_rr_inhibit <= 1'b0;
            r_hold       <= '0;
            fb_sel_o     <= c_FB_NATIVE;
        end else begin
            r_pend_e <= (r_pend_e && !w_grant_e) || excite_req_i;
            r_pend_i <= (r_pend_i && !w_grant_i) || inhibit_req_i;
            if (lfsr_en_o) begin
                if (w_grant_e) begin
                    fb_sel_o     <= c_FB_EXCITE;
                    r_hold       <= HW'(HOLD_CYCLES);
                    r_rr_inhibit <= 1'b1;
                end else if (w_grant_i) begin
                    fb_sel_o     <= c_FB_INHIBIT;
                    r_hold       <= HW'(HOLD_CYCLES);
                    r_rr_inhibit <= 1'b0;
                end else begin
                    if (r_hold != '0)
                        r_hold <= r_hold - HW'(1);
                    if (w_arb)
                        fb_sel_o <= c_FB_NATIVE;
                end
            end
        end
    end

endmodule
`default_nettype wire
